// File: rtl/vga_draw_pkg.sv
// rtl/vga_draw_pkg.sv - shared VGA drawing constants, state encoding and helpers
package vga_draw_pkg;

  localparam int X_SCREEN_PIXELS = 320;
  localparam int Y_SCREEN_PIXELS = 240;
  localparam int X_W = 9;
  localparam int Y_W = 8;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] YELLOW = 3'b110;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} draw_state_t;

  // Width of a box raster counter: enough bits for the larger box side, at least one.
  function automatic int cnt_width(input int w, input int h);
    int m;
    m = (w > h) ? w : h;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_highlight_engine_if.sv
// rtl/key_highlight_engine_if.sv - VGA adapter pixel write port
interface key_highlight_engine_if
  import vga_draw_pkg::*;
  ;
  logic [X_W-1:0] oX;
  logic [Y_W-1:0] oY;
  logic [2:0]     oColour;
  logic           oPlot;

  modport master (output oX, output oY, output oColour, output oPlot);
  modport slave  (input oX, input oY, input oColour, input oPlot);
endinterface

// File: rtl/key_pos_rom.sv
// rtl/key_pos_rom.sv - key index to on-screen box origin and base colour
module key_pos_rom
  import vga_draw_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [2:0]       colour
);

  logic [31:0] sel;

  // Notes 0..11 run C..B (white row y=124, black row y=96); 12..15 are the octave/ADSR buttons.
  always_comb begin
    sel = 32'(idx);
    {x, y, colour} = {9'd0, 8'd0, BLACK};
    case (sel)
      0:  {x, y, colour} = {9'd66,  8'd124, WHITE};
      1:  {x, y, colour} = {9'd81,  8'd96,  BLACK};
      2:  {x, y, colour} = {9'd97,  8'd124, WHITE};
      3:  {x, y, colour} = {9'd112, 8'd96,  BLACK};
      4:  {x, y, colour} = {9'd129, 8'd124, WHITE};
      5:  {x, y, colour} = {9'd161, 8'd124, WHITE};
      6:  {x, y, colour} = {9'd176, 8'd96,  BLACK};
      7:  {x, y, colour} = {9'd192, 8'd124, WHITE};
      8:  {x, y, colour} = {9'd207, 8'd96,  BLACK};
      9:  {x, y, colour} = {9'd223, 8'd124, WHITE};
      10: {x, y, colour} = {9'd238, 8'd96,  BLACK};
      11: {x, y, colour} = {9'd254, 8'd124, WHITE};
      12: {x, y, colour} = {9'd71,  8'd169, WHITE};
      13: {x, y, colour} = {9'd103, 8'd169, WHITE};
      14: {x, y, colour} = {9'd153, 8'd169, WHITE};
      15: {x, y, colour} = {9'd183, 8'd169, WHITE};
      default: {x, y, colour} = {9'd0, 8'd0, BLACK};
    endcase
  end

endmodule

// File: rtl/key_highlight_engine.sv
// rtl/key_highlight_engine.sv - per-key highlight box painter driving the VGA pixel port
module key_highlight_engine
  import vga_draw_pkg::*;
#(
  parameter int          NUM_KEYS  = 16,
  parameter int          BOX_W     = 4,
  parameter int          BOX_H     = 4,
  parameter logic [2:0]  ON_COLOUR = 3'b110
) (
  input  logic                    iClock,
  input  logic                    iResetn,
  input  logic [NUM_KEYS-1:0]     iKeys,
  input  logic                    iRefresh,
  key_highlight_engine_if.master  pix,
  output logic                    oBusy
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W = cnt_width(BOX_W, BOX_H);
  localparam logic [CNT_W-1:0] CX_LAST = CNT_W'(BOX_W - 1);
  localparam logic [CNT_W-1:0] CY_LAST = CNT_W'(BOX_H - 1);

  draw_state_t          state_q, state_d;
  logic [NUM_KEYS-1:0]  shown_q, shown_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 target_q, target_d;
  logic [X_W-1:0]       bx_q, bx_d, x_q, x_d;
  logic [Y_W-1:0]       by_q, by_d, y_q, y_d;
  logic [CNT_W-1:0]     cx_q, cx_d, cy_q, cy_d;
  logic [2:0]           colour_q, colour_d;
  logic                 plot_q, plot_d;
  logic                 busy_q, busy_d;

  logic [NUM_KEYS-1:0]  pending;
  logic [IDX_W-1:0]     low_idx;
  logic [X_W-1:0]       rom_x;
  logic [Y_W-1:0]       rom_y;
  logic [2:0]           rom_colour;

  assign pending = iKeys ^ shown_q;

  key_pos_rom #(.IDX_W(IDX_W)) u_rom (
    .idx    (idx_q),
    .x      (rom_x),
    .y      (rom_y),
    .colour (rom_colour)
  );

  // Fixed priority: lowest pending key index wins.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[k]) low_idx = IDX_W'(k);
    end
  end

  // Next-state logic: pick a key, fetch its box, raster it one pixel per cycle, commit shown[].
  always_comb begin
    state_d  = state_q;
    shown_d  = shown_q;
    idx_d    = idx_q;
    target_d = target_q;
    bx_d     = bx_q;
    by_d     = by_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          idx_d    = low_idx;
          target_d = iKeys[low_idx];
          state_d  = LOAD;
        end
      end
      LOAD: begin
        bx_d     = rom_x;
        by_d     = rom_y;
        cx_d     = '0;
        cy_d     = '0;
        x_d      = rom_x;
        y_d      = rom_y;
        colour_d = target_q ? ON_COLOUR : rom_colour;
        plot_d   = 1'b1;
        state_d  = DRAW;
      end
      DRAW: begin
        if (cx_q == CX_LAST && cy_q == CY_LAST) begin
          state_d = DONE;
        end else begin
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + CNT_W'(1);
          end else begin
            cx_d = cx_q + CNT_W'(1);
          end
          x_d    = bx_q + X_W'(cx_d);
          y_d    = by_q + Y_W'(cy_d);
          plot_d = 1'b1;
        end
      end
      DONE: begin
        shown_d[idx_q] = target_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A background redraw wipes every highlight, so everything becomes pending again.
    if (iRefresh) shown_d = ~iKeys;
    busy_d = (state_d != IDLE);
  end

  // State and registered pixel outputs; synchronous reset aborts any box in flight.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q  <= IDLE;
      shown_q  <= '0;
      idx_q    <= '0;
      target_q <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shown_q  <= shown_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
    end
  end

  assign pix.oX      = x_q;
  assign pix.oY      = y_q;
  assign pix.oColour = colour_q;
  assign pix.oPlot   = plot_q;
  assign oBusy       = busy_q;

endmodule

// File: doc/key_highlight_engine.md
Name: key_highlight_engine

Overview:
- Parametrised successor to the single-note VGA highlighter.
- Tracks NUM_KEYS independent key/button channels: 12 notes, octave +/-, ADSR +/-.
- Draws a BOX_W x BOX_H highlight on each press and erases it to the key's base colour on release.
- Queues simultaneous events, serves them one box at a time, and drives the VGA adapter pixel port (oX/oY/oColour/oPlot).

Parameters:
- NUM_KEYS, 16, number of key channels; index selects a screen position from key_pos_rom.
- BOX_W, 4, highlight width in pixels (1..16).
- BOX_H, 4, highlight height in pixels (1..16).
- ON_COLOUR, 3'b110, highlight colour (yellow).

Ports:
- iClock  in  1  system clock
- iResetn  in  1  reset
- iKeys  in  NUM_KEYS  level key state, 1 = pressed; synchronous to iClock
- iRefresh  in  1  single-cycle pulse: background was redrawn, repaint all keys
- oX  out  9  pixel x
- oY  out  8  pixel y
- oColour  out  3  pixel colour
- oPlot  out  1  pixel write strobe
- oBusy  out  1  high while not IDLE

Behaviour:
- Reset: iResetn, synchronous, active-low; clock iClock.
  - All state is cleared in the cycle reset is sampled low.
  - shown[] = 0 (screen assumed unhighlighted), FSM = IDLE.
  - oX = 0, oY = 0, oColour = 0, oPlot = 0, oBusy = 0.
- Tracking:
  - Per key, shown[k] is the state currently displayed.
  - pending[k] = iKeys[k] XOR shown[k], evaluated combinationally.
- iRefresh (sampled in any state): shown[] <= ~iKeys on the next edge, so every key becomes pending and is repainted.
  - If iRefresh and a DONE write hit the same cycle, iRefresh wins.
- FSM states and transitions:
  - IDLE: if any pending bit is set, go to LOAD. Latch idx = lowest set pending index and target = iKeys[idx].
  - LOAD: latch bx, by, base colour from key_pos_rom(idx). Clear cx = 0, cy = 0. Go to DRAW.
  - DRAW: each cycle register one pixel:
    - oPlot = 1, oX = bx + cx, oY = by + cy.
    - oColour = ON_COLOUR if target = 1, else the base colour.
    - Order is raster: cx increments first, wraps to 0 at BOX_W-1, then cy increments.
    - After the pixel at (BOX_W-1, BOX_H-1), go to DONE.
  - DONE: shown[idx] <= target, oPlot = 0, go to IDLE.
- Timing:
  - The first pixel strobe appears 2 cycles after IDLE sees pending (IDLE, LOAD, then first DRAW edge).
  - Exactly BOX_W*BOX_H consecutive oPlot cycles per box.
  - Minimum service time per box is BOX_W*BOX_H + 3 cycles, IDLE to IDLE.
  - oPlot is low in IDLE, LOAD and DONE.
- Arithmetic:
  - x/y sums wrap modulo 512/256. ROM entries are guaranteed to lie within 320-BOX_W by 240-BOX_H, so no clipping logic.
  - Counter width is clog2 of max(BOX_W, BOX_H), minimum 1 bit.
- Key changes during a draw:
  - target is frozen for the whole box.
  - If the key toggles mid-draw, pending re-asserts after DONE and the box is redrawn with the new state.
  - Press then release before service means pending clears and nothing is drawn.
- Priority and fairness:
  - Lowest pending index wins.
  - A served key is not pending again unless its input changes, so with NUM_KEYS boxes outstanding every key is drawn within NUM_KEYS services.
- Reset mid-DRAW:
  - Abort immediately; oPlot = 0 on the following cycle.
  - The partial box remains on screen. Software issues iRefresh after background repaint.
- oBusy = (state != IDLE), registered.

Decomposition:
- Shared package vga_draw_pkg holds:
  - X_SCREEN_PIXELS = 320, Y_SCREEN_PIXELS = 240.
  - Colour constants: BLACK 3'b000, WHITE 3'b111, YELLOW 3'b110.
  - The state encoding: IDLE, LOAD, DRAW, DONE.
  - X_W = 9, Y_W = 8.
- Sub-module key_pos_rom: combinational index -> {x[8:0], y[7:0], base_colour[2:0]}.
  - Entries 0..11 are the note keys:
    - White keys use y = 124, base colour WHITE.
    - Black keys use y = 96, base colour BLACK.
  - 12..15 are octave-, octave+, ADSR+, ADSR- at (71,169), (103,169), (153,169), (183,169), base colour WHITE.
  - Out-of-range indices return (0, 0, BLACK).

Test Plan:
- Reset then iKeys = 0 for 20 cycles -> oPlot never high, oBusy = 0, oX = oY = 0.
- Press key 0 (pos 66,124) -> after 2 cycles, 16 consecutive plots colour 3'b110 covering x 66..69, y 124..127 in raster order; shown[0] = 1; release -> 16 plots colour 3'b111 at the same coordinates.
- Press keys 5 and 1 in the same cycle -> key 1 box (81,96) fully drawn before key 5 (161,124); a 3-cycle gap with oPlot = 0 between the boxes.
- Press key 3 and release it after 5 DRAW cycles -> full yellow box at (112,96) completes, then a full BLACK erase box follows; final shown[3] = 0.
- Pulse press/release of key 7 while engine busy on key 2 -> no box ever drawn at (192,124).
- Hold keys 12 and 14, then pulse iRefresh with iKeys = 0x5000 -> all 16 keys redrawn in index order (16x16 plots); keys 12 and 14 in 3'b110, others in base colour. Assert iResetn low mid-DRAW -> oPlot = 0 next cycle and all outputs 0.
